// File: rtl/magma_iter_core.sv
// Iterative GOST 28147-89 / Magma 64-bit block cipher core.
// ROUNDS_PER_CYCLE Feistel rounds are folded into each clock.
// Valid/ready handshakes are used on both the input and output sides.
module magma_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int SBOX_SET         = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [255:0] key,
  input  logic [63:0]  data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy
);

  // An unsupported fold factor is rejected at elaboration time.
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rpc
    $error("magma_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  // Each box is 16 nibbles with entry 0 in the leftmost hex digit.
  // Box 0 acts on bits [31:28] and box 7 acts on bits [3:0].
  // For set 1, box j is Pi(7-j) of GOST R 34.12-2015.
  localparam logic [63:0] SBOX1 [8] = '{
    64'h17ED05834FA69CB2, 64'h8E25691CF4B0DA37, 64'h5DF692CAB78143E0, 64'h7F5A816D093EB42C,
    64'hC821D4F670A53E9B, 64'hB3582FADE174C960, 64'h68239A5C1E47BD0F, 64'hC462A5B9E8D703F1
  };
  localparam logic [63:0] SBOX0 [8] = '{
    64'h1FD057A4923E6B8C, 64'hDB413F590AE7682C, 64'h4BA0721D36859CFE, 64'h6C715FD84A9E03B2,
    64'h7DA1089FE46CB253, 64'h581DA342EFC7609B, 64'hEB4C6DFA23810759, 64'h4A92D80E6B1C7F53
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_mode;
  logic [255:0]  r_key;
  logic [31:0]   r_a1, r_a0;
  logic [5:0]    r_rnd;
  logic [63:0]   r_data_out;
  logic [31:0]   w_a1_nxt, w_a0_nxt;
  logic          w_last;

  function automatic logic [3:0] box_lookup(input int j, input logic [3:0] v);
    logic [63:0] tbl;
    tbl = (SBOX_SET == 1) ? SBOX1[j] : SBOX0[j];
    return tbl[6'd60 - {v, 2'b00} +: 4];
  endfunction

  function automatic logic [31:0] g_func(input logic [31:0] x, input logic [31:0] k);
    logic [31:0] sum, sub;
    sum = x + k;
    for (int j = 0; j < 8; j++) sub[(7-j)*4 +: 4] = box_lookup(j, sum[(7-j)*4 +: 4]);
    return {sub[20:0], sub[31:21]};  // true rotate left by 11
  endfunction

  // In encrypt mode, rounds 0..23 walk forward through K1..K8 and the last 8 rounds walk backward.
  // In decrypt mode, only rounds 0..7 walk forward.
  function automatic logic [31:0] key_sel(input logic [4:0] r, input logic m, input logic [255:0] k);
    logic       fwd;
    logic [2:0] idx;
    fwd = m ? (r < 5'd8) : (r < 5'd24);
    idx = fwd ? ~r[2:0] : r[2:0];
    return k[{idx, 5'b00000} +: 32];
  endfunction

  // Unrolled Feistel rounds for one clock, using consecutive round indices.
  always_comb begin : rounds
    logic [31:0] v_t;
    logic [4:0]  v_r;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_a1_nxt = r_a1;
    w_a0_nxt = r_a0;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      v_r      = r_rnd[4:0] + 5'(i);
      v_t      = w_a1_nxt ^ g_func(w_a0_nxt, key_sel(v_r, r_mode, r_key));
      w_a1_nxt = w_a0_nxt;
      w_a0_nxt = v_t;
    end
  end

  assign w_last = (r_rnd == 6'(32 - ROUNDS_PER_CYCLE));

  // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, operand latches, round counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register is cleared on reset so an abandoned block leaves nothing behind;
    // non-blocking assignments keep all flops updating from pre-edge values.
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_key      <= '0;
      r_a1       <= '0;
      r_a0       <= '0;
      r_rnd      <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && in_valid) begin
        r_mode <= mode;
        r_key  <= key;
        r_a1   <= data_in[63:32];
        r_a0   <= data_in[31:0];
        r_rnd  <= '0;
      end else if (r_state == S_RUN) begin
        r_a1  <= w_a1_nxt;
        r_a0  <= w_a0_nxt;
        r_rnd <= r_rnd + 6'(ROUNDS_PER_CYCLE);
        if (w_last) r_data_out <= {w_a0_nxt, w_a1_nxt};
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign data_out  = r_data_out;

endmodule
